// File: rtl/addr_bus_arbiter.sv
// Address-bus master: arbitrates NUM_SRC requesters, latches the winner's address,
// holds it for SETTLE_CYCLES, then strobes addr_valid/ack. Define ADDR_BUS_RR_EN for round-robin.
module addr_bus_arbiter #(
  parameter int ADDR_BUS_WIDTH = 16,
  parameter int NUM_SRC        = 5,
  parameter int SETTLE_CYCLES  = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_SRC-1:0]                req_i,
  input  logic [NUM_SRC*ADDR_BUS_WIDTH-1:0] src_addr_i,
  output logic [NUM_SRC-1:0]                grant_o,
  output logic [NUM_SRC-1:0]                ack_o,
  output logic [ADDR_BUS_WIDTH-1:0]         address_o,
  output logic                              addr_valid_o,
  output logic                              busy_o
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, VALID, RELEASE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          owner_q, owner_d;
  logic [NUM_SRC-1:0]        grant_q, grant_d;
  logic [ADDR_BUS_WIDTH-1:0] address_q, address_d;

  logic [ADDR_BUS_WIDTH-1:0] srcAddr [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : gUnpack
    assign srcAddr[g] = src_addr_i[g*ADDR_BUS_WIDTH +: ADDR_BUS_WIDTH];
  end

  logic [IDX_W-1:0] searchBase;

`ifdef ADDR_BUS_RR_EN
  logic [IDX_W-1:0] lastWinner_q;

  // Search begins just past the last source that completed a transfer.
  assign searchBase = (lastWinner_q == IDX_W'(NUM_SRC-1)) ? '0 : lastWinner_q + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      lastWinner_q <= '0;
    end else if (state_q == VALID) begin
      lastWinner_q <= owner_q;
    end
  end
`else
  assign searchBase = '0;
`endif

  logic             winFound;
  logic [IDX_W-1:0] winIdx;
  logic [IDX_W-1:0] cand;

  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    cand     = searchBase;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!winFound && req_i[cand]) begin
        winFound = 1'b1;
        winIdx   = cand;
      end
      cand = (cand == IDX_W'(NUM_SRC-1)) ? '0 : cand + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      address_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      address_q <= address_d;
    end
  end

  // RELEASE doubles as an arbitration slot, so a request still held after it
  // starts a new transfer on the edge leaving RELEASE (E+SETTLE_CYCLES+2).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    address_d = address_q;
    unique case (state_q)
      IDLE, RELEASE: begin
        state_d   = IDLE;
        grant_d   = '0;
        address_d = '0;
        if (winFound) begin
          state_d   = SETTLE;
          owner_d   = winIdx;
          grant_d   = NUM_SRC'(1) << winIdx;
          address_d = srcAddr[winIdx];
          cnt_d     = CNT_W'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (!req_i[owner_q]) begin
          state_d   = RELEASE;
          grant_d   = '0;
          address_d = '0;
        end else if (cnt_q == '0) begin
          state_d = VALID;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      VALID: begin
        state_d   = RELEASE;
        grant_d   = '0;
        address_d = '0;
      end
      default: begin
        state_d   = IDLE;
        grant_d   = '0;
        address_d = '0;
      end
    endcase
  end

  // Reset masks the strobes directly so a VALID cycle cut short by reset never acks.
  assign addr_valid_o = (state_q == VALID) && !reset;
  assign ack_o        = addr_valid_o ? grant_q : '0;
  assign grant_o      = grant_q;
  assign address_o    = address_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_addr_bus_arbiter.sv
// Self-checking bench for addr_bus_arbiter: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_addr_bus_arbiter;

  localparam int W      = 16;
  localparam int NSRC   = 5;
  localparam int SETTLE = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NSRC-1:0] req = '0;
  logic [NSRC*W-1:0] srcBus;
  logic [NSRC-1:0] grant;
  logic [NSRC-1:0] ack;
  logic [W-1:0]    address;
  logic            addrValid;
  logic            busy;
  logic [W-1:0]    srcA [NSRC];

  for (genvar g = 0; g < NSRC; g++) begin : gPack
    assign srcBus[g*W +: W] = srcA[g];
  end

  addr_bus_arbiter #(
    .ADDR_BUS_WIDTH(W),
    .NUM_SRC(NSRC),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_i(req),
    .src_addr_i(srcBus),
    .grant_o(grant),
    .ack_o(ack),
    .address_o(address),
    .addr_valid_o(addrValid),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycleNo = 0;

  // Reference model: owner index, cycles since grant (1..SETTLE settling,
  // SETTLE+1 valid), and a release flag.
  int           mOwner = -1;
  int           mAge = 0;
  bit           mRel = 1'b0;
  int           mPtr = 0;
  logic [W-1:0] mAddr = '0;

  logic [NSRC-1:0] eGrant, eAck;
  logic [W-1:0]    eAddr;
  logic            eValid, eBusy;

  function automatic int pickWinner(logic [NSRC-1:0] r);
    int order[$];
`ifdef ADDR_BUS_RR_EN
    for (int k = 1; k <= NSRC; k++) order.push_back((mPtr + k) % NSRC);
`else
    for (int k = 0; k < NSRC; k++) order.push_back(k);
`endif
    foreach (order[j]) if (r[order[j]]) return order[j];
    return -1;
  endfunction

  function automatic void modelStep();
    if (reset) begin
      mOwner = -1;
      mRel   = 1'b0;
      mAge   = 0;
      mPtr   = 0;
    end else if (mOwner >= 0 && !mRel) begin
      if (mAge <= SETTLE) begin
        if (!req[mOwner]) mRel = 1'b1;
        else mAge++;
      end else begin
        mRel = 1'b1;
        mPtr = mOwner;
      end
    end else begin
      mRel   = 1'b0;
      mOwner = pickWinner(req);
      if (mOwner >= 0) begin
        mAge  = 1;
        mAddr = srcA[mOwner];
      end
    end
  endfunction

  function automatic void computeExpected();
    bit owned;
    owned  = (mOwner >= 0) && !mRel;
    eGrant = owned ? (NSRC'(1) << mOwner) : '0;
    eAddr  = owned ? mAddr : '0;
    eValid = owned && (mAge == SETTLE + 1) && !reset;
    eAck   = eValid ? eGrant : '0;
    eBusy  = (mOwner >= 0);
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got %h expected %h", name, cycleNo, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [NSRC-1:0] r);
    @(posedge clk);
    modelStep();
    #1;
    reset = rst;
    req   = r;
    #1;
    cycleNo++;
    computeExpected();
  endtask

  task automatic checkOutput();
    checkVal("grant", 32'(grant), 32'(eGrant));
    checkVal("ack", 32'(ack), 32'(eAck));
    checkVal("address", 32'(address), 32'(eAddr));
    checkVal("addr_valid", 32'(addrValid), 32'(eValid));
    checkVal("busy", 32'(busy), 32'(eBusy));
    checkVal("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    checkVal("ack_subset_grant", 32'(|(ack & ~grant)), 32'd0);
  endtask

  // Drive a request set, retire each source on its ack, and verify order and spacing.
  task automatic runBurst(input string tag, input logic [NSRC-1:0] r, input int n,
                          input int e0, input int e1, input int e2);
    logic [NSRC-1:0] rv;
    int got[$];
    int ackCyc[$];
    int expOrder[3];
    int cyc;
    rv = r;
    cyc = 0;
    expOrder = '{e0, e1, e2};
    while (got.size() < n && cyc < 60) begin
      applyStimulus(1'b0, rv);
      checkOutput();
      cyc++;
      for (int i = 0; i < NSRC; i++) begin
        if (ack[i]) begin
          got.push_back(i);
          ackCyc.push_back(cyc);
          rv[i] = 1'b0;
        end
      end
    end
    checkVal({tag, ".ack_count"}, 32'(got.size()), 32'(n));
    for (int k = 0; k < n && k < got.size(); k++)
      checkVal($sformatf("%s.order%0d", tag, k), 32'(got[k]), 32'(expOrder[k]));
    for (int k = 1; k < got.size(); k++)
      checkVal($sformatf("%s.gap%0d", tag, k), 32'(ackCyc[k] - ackCyc[k-1]), 32'(SETTLE + 2));
    applyStimulus(1'b0, '0);
    checkOutput();
    applyStimulus(1'b0, '0);
    checkOutput();
  endtask

  typedef struct {
    logic            rst;
    logic [NSRC-1:0] req;
    logic [NSRC-1:0] grant;
    logic [NSRC-1:0] ack;
    logic [W-1:0]    addr;
    logic            valid;
    logic            busy;
  } vec_t;

  vec_t tbl [19];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NSRC-1:0] rv;
    logic [NSRC-1:0] lastAck;
    int ackCyc[$];
    bit seen;

    srcA[0] = 16'h0010;
    srcA[1] = 16'h1111;
    srcA[2] = 16'h2222;
    srcA[3] = 16'hA5C3;
    srcA[4] = 16'h4444;

    // rst, req, grant, ack, addr, valid, busy (outputs seen after the edge)
    tbl[0]  = '{1'b0, 5'b01000, 5'b00000, 5'b00000, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 5'b01000, 5'b01000, 5'b00000, 16'hA5C3, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 5'b01000, 5'b01000, 5'b00000, 16'hA5C3, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 5'b01000, 5'b01000, 5'b00000, 16'hA5C3, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 5'b00000, 5'b01000, 5'b01000, 16'hA5C3, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 16'h0000, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 16'h0000, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 5'b00100, 5'b00000, 5'b00000, 16'h0000, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 5'b00100, 5'b00100, 5'b00000, 16'h2222, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 5'b00000, 5'b00100, 5'b00000, 16'h2222, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 16'h0000, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 16'h0000, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 5'b00001, 5'b00000, 5'b00000, 16'h0000, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 5'b00001, 5'b00001, 5'b00000, 16'h0010, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 5'b00001, 5'b00001, 5'b00000, 16'h0010, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 5'b00001, 5'b00001, 5'b00000, 16'h0010, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 5'b00001, 5'b00001, 5'b00000, 16'h0010, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 16'h0000, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 16'h0000, 1'b0, 1'b0};

    $display("[TB] reset");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, '0);
      checkOutput();
    end
    checkVal("reset.grant", 32'(grant), 32'd0);
    checkVal("reset.busy", 32'(busy), 32'd0);

    $display("[TB] vector table");
    for (int i = 0; i < 19; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].req);
      checkOutput();
      checkVal($sformatf("tbl%0d.grant", i), 32'(grant), 32'(tbl[i].grant));
      checkVal($sformatf("tbl%0d.ack", i), 32'(ack), 32'(tbl[i].ack));
      checkVal($sformatf("tbl%0d.address", i), 32'(address), 32'(tbl[i].addr));
      checkVal($sformatf("tbl%0d.valid", i), 32'(addrValid), 32'(tbl[i].valid));
      checkVal($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].busy));
    end

    $display("[TB] simultaneous requests");
    runBurst("burst_a", 5'b10110, 3, 1, 2, 4);
    runBurst("single3", 5'b01000, 1, 3, 0, 0);
`ifdef ADDR_BUS_RR_EN
    runBurst("burst_b", 5'b10110, 3, 4, 1, 2);
`else
    runBurst("burst_b", 5'b10110, 3, 1, 2, 4);
`endif

    $display("[TB] address latch");
    srcA[0] = 16'h0010;
    applyStimulus(1'b0, 5'b00001);
    checkOutput();
    applyStimulus(1'b0, 5'b00001);
    checkOutput();
    srcA[0] = 16'hFFFF;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      applyStimulus(1'b0, 5'b00001);
      checkOutput();
      if (addrValid) begin
        checkVal("latch.address", 32'(address), 32'h0010);
        seen = 1'b1;
      end
    end
    checkVal("latch.valid_seen", 32'(seen), 32'd1);
    applyStimulus(1'b0, '0);
    checkOutput();
    applyStimulus(1'b0, '0);
    checkOutput();

    $display("[TB] continuous request");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 5'b00001);
      checkOutput();
      if (ack[0]) ackCyc.push_back(i);
    end
    checkVal("cont.ack_count", 32'(ackCyc.size()), 32'd4);
    for (int k = 1; k < ackCyc.size(); k++)
      checkVal($sformatf("cont.gap%0d", k), 32'(ackCyc[k] - ackCyc[k-1]), 32'(SETTLE + 2));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0);
      checkOutput();
    end

    $display("[TB] random traffic");
    rv = '0;
    lastAck = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NSRC; i++) begin
        if (rv[i] && lastAck[i]) rv[i] = 1'b0;
        else if (!rv[i] && $urandom_range(3) == 0) rv[i] = 1'b1;
        else if (rv[i] && $urandom_range(29) == 0) rv[i] = 1'b0;
      end
      if ($urandom_range(7) == 0) srcA[$urandom_range(NSRC-1)] = W'($urandom);
      applyStimulus(($urandom_range(59) == 0), rv);
      checkOutput();
      lastAck = eAck;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
